bias_loader: RTL

Streaming writer for the bias vector used by the classifier output stage. It accepts signed bias words one per handshake, collects a full vector of `N` entries in a shadow buffer, then commits the whole vector at once to a parallel `bias` array. The adder stage therefore always sees a complete, stable set. The block sits between the weight/bias memory interface and the bias adder's `bias[N]` input; it drives the other end of that port.

---
 rtl/bias_loader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/bias_loader.sv
// ---------------------------------------------------------------------------
// bias_loader
//
// Streaming writer for the classifier output-stage bias vector. Signed bias
// words arrive one per valid/ready handshake and are gathered in a shadow
// buffer. Once a full vector of N entries is present, the whole vector is
// copied into the parallel `bias` output register in a single cycle.
// Downstream logic therefore only ever sees a complete, stable vector.
//
// Optional feature (compile-time macro BIAS_LOADER_CHECKSUM_EN):
//   Each vector is followed by one checksum word. This word must equal the
//   W-bit wrapping sum of the N entries. On a mismatch the vector is dropped
//   and `load_err` pulses. Without the macro, `load_err` is tied low.
//
// Parameters:
//   N           number of bias entries per vector
//   W           word width (two's-complement signed)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    in_data holds a word
//   in_data     signed bias word, or the checksum word
//   in_ready    loader can accept a word (decoded from state and rst only)
//   bias        committed bias vector, unpacked [N]
//   bias_valid  bias holds a committed vector; sticky until reset
//   load_done   high during the single commit cycle
//   load_err    one-cycle pulse after a checksum mismatch
//   load_idx    number of entries accepted into the vector being loaded
// ---------------------------------------------------------------------------
module bias_loader #(
    parameter int N = 10,
    parameter int W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [W-1:0]         in_data,
    output logic                        in_ready,
    output logic signed [W-1:0]         bias [N],
    output logic                        bias_valid,
    output logic                        load_done,
    output logic                        load_err,
    output logic [$clog2(N+1)-1:0]      load_idx
);

    localparam int IW = $clog2(N+1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

`ifdef BIAS_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        COMMIT = 2'd2
    } state_t;
`endif

    state_t                 state;
    logic [IW-1:0]          idx;
    logic signed [W-1:0]    shadow [N];
    logic                   xfer;

    // Ready does not look at in_valid, so a source may hold its word across
    // the commit cycle. The word then transfers as soon as LOAD resumes.
    assign in_ready  = !rst && (state != COMMIT);
    assign xfer      = in_valid && in_ready;
    assign load_idx  = idx;

    // Gate with rst so that a reset landing on the commit cycle never shows
    // a completion.
    assign load_done = !rst && (state == COMMIT);

    // Shadow capture: data path, intentionally not reset
    always_ff @(posedge clk) begin
        if (xfer && (state == LOAD)) begin
            shadow[idx] <= in_data;
        end
    end

`ifdef BIAS_LOADER_CHECKSUM_EN
    logic signed [W-1:0]    sum_p0;
    logic                   sum_match;

    // Modular accumulation: the carry out of bit W-1 is discarded.
    function automatic logic signed [W-1:0] wrap_add(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        return a + b;
    endfunction

    // Running checksum: the first entry of a vector restarts the sum.
    // No reset is needed, because idx==0 always reseeds the sum.
    always_ff @(posedge clk) begin
        if (xfer && (state == LOAD)) begin
            sum_p0 <= (idx == '0) ? in_data : wrap_add(sum_p0, in_data);
        end
    end

    assign sum_match = (in_data == sum_p0);
`endif

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            idx        <= '0;
            bias_valid <= 1'b0;
`ifdef BIAS_LOADER_CHECKSUM_EN
            load_err   <= 1'b0;
`endif
        end else begin
`ifdef BIAS_LOADER_CHECKSUM_EN
            load_err <= 1'b0;
`endif
            case (state)
                LOAD: begin
                    if (xfer) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
`ifdef BIAS_LOADER_CHECKSUM_EN
                            state <= CHECK;
`else
                            state <= COMMIT;
`endif
                        end
                    end
                end
`ifdef BIAS_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (xfer) begin
                        if (sum_match) begin
                            state <= COMMIT;
                        end else begin
                            // Drop the vector and keep the committed one.
                            load_err <= 1'b1;
                            idx      <= '0;
                            state    <= LOAD;
                        end
                    end
                end
`endif
                COMMIT: begin
                    bias_valid <= 1'b1;
                    idx        <= '0;
                    state      <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

`ifndef BIAS_LOADER_CHECKSUM_EN
    assign load_err = 1'b0;
`endif

    // Committed output register: updated only in COMMIT, so partial
    // vectors are never visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                bias[i] <= '0;
            end
        end else if (state == COMMIT) begin
            for (int i = 0; i < N; i++) begin
                bias[i] <= shadow[i];
            end
        end
    end

endmodule
